// File: rtl/uart_fifo_param.sv
// Parametrised synchronous FIFO between the UART shift engines and the controller.
// Occupancy, almost-full/almost-empty thresholds, sticky error flags, synchronous
// flush, and a choice of fall-through or registered read data.
module uart_fifo_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 2,
  parameter bit          FWFT     = 1'b1
) (
  input  logic              baudClk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_CNT = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_CNT = PTR_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              en_read;
  logic              en_write;
  logic [DATA_W-1:0] head_word;

  // Status derived from the registered pointers; the MSB is the wrap bit.
  always_comb begin
    full         = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    empty        = (wptr == rptr);
    count        = wptr - rptr;
    almost_full  = (count >= AF_CNT);
    almost_empty = (count <= AE_CNT);
  end

  // Accept rules: a read frees a slot, so a write into a full FIFO succeeds alongside it.
  always_comb begin
    en_read   = rd & ~empty;
    en_write  = wr & (~full | en_read);
    head_word = mem[rptr[ADDR_W-1:0]];
  end

  // Pointer update; flush has priority over any request in the same cycle.
  always_ff @(posedge baudClk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (en_write) wptr <= wptr + PTR_W'(1);
      if (en_read)  rptr <= rptr + PTR_W'(1);
    end
  end

  // Sticky error flags, cleared only by flush or reset.
  always_ff @(posedge baudClk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr & full & ~en_read) overflow  <= 1'b1;
      if (rd & empty)           underflow <= 1'b1;
    end
  end

  // Storage array; intentionally not reset or flushed.
  always_ff @(posedge baudClk) begin
    if (en_write && !clear) mem[wptr[ADDR_W-1:0]] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head of queue presented directly; zero while nothing is stored.
      always_comb begin
        data_out = empty ? '0 : head_word;
      end
    end else begin : g_reg
      logic [DATA_W-1:0] data_q;

      // Output register loads the head word on an accepted read and holds otherwise.
      always_ff @(posedge baudClk or negedge reset_n) begin
        if (!reset_n) begin
          data_q <= '0;
        end else if (clear) begin
          data_q <= '0;
        end else if (en_read) begin
          data_q <= head_word;
        end
      end

      assign data_out = data_q;
    end
  endgenerate

endmodule

// File: tb/tb_uart_fifo_param.sv
// Bench for uart_fifo_param: one fall-through and one registered-read instance share
// the same stimulus and are compared every cycle against a queue-based model.
module tb_uart_fifo_param;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] dout_f, dout_r;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic       full_r, empty_r, af_r, ae_r, ovf_r, udf_r;
  logic [4:0] cnt_f, cnt_r;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1'b1)) u_fwft (
    .baudClk(clk), .reset_n(reset_n), .clear(clear), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(cnt_f), .overflow(ovf_f), .underflow(udf_f));

  uart_fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1'b0)) u_reg (
    .baudClk(clk), .reset_n(reset_n), .clear(clear), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(dout_r), .full(full_r), .empty(empty_r), .almost_full(af_r),
    .almost_empty(ae_r), .count(cnt_r), .overflow(ovf_r), .underflow(udf_r));

  // Reference model: the FIFO contents as a plain queue.
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  logic [7:0] m_dreg = 8'h00;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_dreg = 8'h00;
    end else if (clear) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_dreg = 8'h00;
    end else begin
      bit was_full, was_empty, take, put;
      was_full  = (q.size() == 16);
      was_empty = (q.size() == 0);
      take = rd && !was_empty;
      put  = wr && (!was_full || take);
      if (wr && was_full && !take) m_ovf = 1'b1;
      if (rd && was_empty)         m_udf = 1'b1;
      if (take) begin
        m_dreg = q[0];
        void'(q.pop_front());
      end
      if (put) q.push_back(data_in);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int unsigned n;
    logic [7:0] head;
    n = q.size();
    head = (n == 0) ? 8'h00 : q[0];
    check("count_f", 32'(cnt_f), n);
    check("count_r", 32'(cnt_r), n);
    check("full_f", 32'(full_f), 32'(n == 16));
    check("full_r", 32'(full_r), 32'(n == 16));
    check("empty_f", 32'(empty_f), 32'(n == 0));
    check("empty_r", 32'(empty_r), 32'(n == 0));
    check("afull_f", 32'(af_f), 32'(n >= 12));
    check("afull_r", 32'(af_r), 32'(n >= 12));
    check("aempty_f", 32'(ae_f), 32'(n <= 2));
    check("aempty_r", 32'(ae_r), 32'(n <= 2));
    check("ovf_f", 32'(ovf_f), 32'(m_ovf));
    check("ovf_r", 32'(ovf_r), 32'(m_ovf));
    check("udf_f", 32'(udf_f), 32'(m_udf));
    check("udf_r", 32'(udf_r), 32'(m_udf));
    check("dout_f", 32'(dout_f), 32'(head));
    check("dout_r", 32'(dout_r), 32'(m_dreg));
  end

  // One clock of stimulus; returns just after the active edge.
  task automatic cyc(input bit w, input bit r, input logic [7:0] d, input bit c);
    @(negedge clk);
    wr = w;
    rd = r;
    data_in = d;
    clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_phase(input int cycles, input int wr_pct, input int rd_pct);
    for (int i = 0; i < cycles; i++) begin
      cyc($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) < rd_pct,
          8'($urandom_range(0, 255)), $urandom_range(0, 59) == 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(cnt_f), 0);
    check("rst_empty", 32'(empty_f), 1);
    check("rst_aempty", 32'(ae_r), 1);
    check("rst_dout_r", 32'(dout_r), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Fill with 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b0);
      check("fill_count", 32'(cnt_f), i);
      if (i == 2)  check("ae_at2", 32'(ae_f), 1);
      if (i == 3)  check("ae_at3", 32'(ae_f), 0);
      if (i == 11) check("af_at11", 32'(af_f), 0);
      if (i == 12) check("af_at12", 32'(af_f), 1);
    end
    check("fill_full", 32'(full_f), 1);
    check("fill_head", 32'(dout_f), 32'h01);

    // Rejected 17th write.
    cyc(1'b1, 1'b0, 8'hAA, 1'b0);
    check("ovf_set_f", 32'(ovf_f), 1);
    check("ovf_set_r", 32'(ovf_r), 1);
    check("ovf_count", 32'(cnt_r), 16);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("ovf_sticky", 32'(ovf_f), 1);
    check("ovf_head", 32'(dout_f), 32'h01);

    // Simultaneous read+write while full.
    cyc(1'b1, 1'b1, 8'h55, 1'b0);
    check("rw_full_count", 32'(cnt_f), 16);
    check("rw_full_rd", 32'(dout_r), 32'h01);
    check("rw_full_head", 32'(dout_f), 32'h02);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("last_head", 32'(dout_f), 32'h55);
    check("last_rd_r", 32'(dout_r), 32'h10);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("drain_rd_r", 32'(dout_r), 32'h55);
    check("drain_empty", 32'(empty_f), 1);
    check("drain_dout_f", 32'(dout_f), 0);

    // Read+write while empty.
    cyc(1'b1, 1'b1, 8'h33, 1'b0);
    check("udf_set", 32'(udf_f), 1);
    check("udf_count", 32'(cnt_f), 1);
    check("udf_head", 32'(dout_f), 32'h33);
    check("udf_hold_r", 32'(dout_r), 32'h55);

    // Flush.
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_count", 32'(cnt_f), 0);
    check("clr_ovf", 32'(ovf_r), 0);
    check("clr_udf", 32'(udf_r), 0);
    check("clr_dout_r", 32'(dout_r), 0);

    // Registered read latency and hold on rejected read.
    cyc(1'b1, 1'b0, 8'h7E, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("reg_rd", 32'(dout_r), 32'h7E);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("reg_hold", 32'(dout_r), 32'h7E);
    check("reg_udf", 32'(udf_r), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Interleaved traffic across pointer wrap.
    for (int i = 0; i < 40; i++) cyc(1'b1, i >= 3, 8'($urandom_range(0, 255)), 1'b0);
    check("wrap_count", 32'(cnt_f), 3);
    cyc(1'b1, 1'b1, 8'hC3, 1'b1);
    check("midclr_count", 32'(cnt_f), 0);
    check("midclr_ovf", 32'(ovf_f), 0);

    // Random traffic: filling, balanced, draining.
    rand_phase(80, 75, 30);
    rand_phase(80, 50, 50);
    rand_phase(80, 25, 70);
    rand_phase(60, 90, 10);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
    reset_n = 1'b0;
    #1;
    check("arst_count", 32'(cnt_f), 0);
    check("arst_empty", 32'(empty_r), 1);
    check("arst_full", 32'(full_f), 0);
    check("arst_afull", 32'(af_f), 0);
    check("arst_aempty", 32'(ae_f), 1);
    check("arst_ovf", 32'(ovf_f), 0);
    check("arst_udf", 32'(udf_r), 0);
    check("arst_dout_f", 32'(dout_f), 0);
    check("arst_dout_r", 32'(dout_r), 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    rand_phase(60, 60, 40);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_fifo_param.md
Name: uart_fifo_param

Overview:
- Parametrised successor to the UART byte FIFO: synchronous single-clock FIFO with configurable data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable read mode (first-word fall-through or registered).
- Sits between the UART RX/TX shift engines and the controller, clocked by the baud clock.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W (16 by default).
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL (legal range 1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (legal range 0..DEPTH-1).
- FWFT, 1, 1 = first-word fall-through read; 0 = registered read with 1-cycle latency.

Ports:
- baudClk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; empties the FIFO and clears the error flags.
- wr  in  1  write request.
- rd  in  1  read request.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full and not accepted.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Pointers:
  - wptr and rptr are ADDR_W+1 bits wide; the MSB is the wrap bit.
  - full = MSBs differ and low bits are equal; empty = pointers are fully equal.
  - count = wptr - rptr, modulo 2**(ADDR_W+1).
  - full, empty, almost_full, almost_empty and count are combinational from the registered pointers.
- Accept rules:
  - enRead = rd & ~empty.
  - enWrite = wr & (~full | enRead). A simultaneous read+write while full is accepted: count stays DEPTH, the oldest word leaves, the new word enters.
  - While empty, a simultaneous rd+wr accepts the write only; the read is rejected and underflow sets.
- Pointer and memory update:
  - An accepted write stores data_in at mem[wptr[ADDR_W-1:0]] and increments wptr.
  - An accepted read increments rptr.
  - Both pointers wrap naturally; the MSB toggles each pass.
- Error flags:
  - overflow sets on wr & full & ~enRead.
  - underflow sets on rd & empty.
  - Both hold until clear or reset.
- Read data, FWFT=1:
  - data_out = mem[rptr] combinationally while non-empty; 0 while empty.
  - After a write into an empty FIFO, data_out shows the word the cycle after the write edge.
- Read data, FWFT=0:
  - data_out is a register loaded with mem[rptr] on an accepted-read edge, so the word is visible the cycle after the rd cycle.
  - It holds its value otherwise, including across rejected reads.
- clear:
  - Has priority over wr/rd in the same cycle.
  - Next edge: wptr = rptr = 0, overflow = underflow = 0, registered data_out = 0.
  - Memory contents are not cleared; the write in that cycle is dropped and is not counted as overflow.
- Reset (reset_n low, any time including mid-transfer):
  - Immediately: pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0 (AF_LEVEL >= 1), overflow = underflow = 0, data_out = 0.
  - Memory is not reset.
  - First accept is on the first rising edge after deassertion.

Test Plan:
- Defaults, FWFT=1, write 0x01..0x10 (16 words) -> full=1 after the 16th edge, count=16, almost_full asserts at count=12, almost_empty drops at count=3; read 16 -> data 0x01..0x10 in order, empty=1.
- Full FIFO, 17th write 0xAA -> rejected, overflow=1 and sticky, count=16; a subsequent read returns 0x01, not 0xAA.
- Full FIFO, wr+rd same cycle with 0x55 -> count stays 16, the read returns 0x01, and 0x55 is read last after 15 more reads.
- Empty FIFO, rd+wr 0x33 same cycle -> underflow=1, count=1; FWFT=1 shows data_out=0x33 the next cycle.
- FWFT=0: write 0x7E, assert rd -> data_out=0x7E one cycle after the rd edge; rd on empty leaves data_out at 0x7E.
- Wrap test, 40 interleaved writes/reads -> ordering preserved across pointer wrap; clear mid-stream gives count=0 and cleared flags; reset_n pulse mid-burst zeroes all outputs asynchronously.
